// File: rtl/conv_mem_bridge.sv
// conv_mem_bridge: serves engine mem_operation/mem_opdone with single Wishbone cycles.
// Optional REQ watchdog with sticky timeout_err: define CONV_BRIDGE_TIMEOUT_EN.
module conv_mem_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_operation,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_opdone,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_HOLD
  } state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t state;
  state_t state_nx;
  logic   we_q;
  logic   req_valid;
  logic   expire;

  // Code 10 is deliberately treated as no request.
  assign req_valid = (mem_operation == 2'b01) ||
                     (mem_operation == 2'b11);

`ifdef CONV_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_inc;
  logic        err_q;

  assign tmo_cnt_inc = tmo_cnt + 16'd1;
  assign expire      = (state == S_REQ) && !wbm_ack_i &&
                       (tmo_cnt_inc == TIMEOUT_CYCLES);
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != S_REQ)
        tmo_cnt <= '0;
      else if (!wbm_ack_i)
        tmo_cnt <= tmo_cnt_inc;
      if (expire)
        err_q <= 1'b1;
    end
  end
`else
  logic [15:0] unused_tmo;

  assign unused_tmo  = TIMEOUT_CYCLES;
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (req_valid) state_nx = S_REQ;
      S_REQ:  if (wbm_ack_i || expire) state_nx = S_DONE;
      S_DONE: state_nx = S_HOLD;
      S_HOLD: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = 4'h0;
    mem_opdone = 1'b0;
    busy       = 1'b1;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = we_q;
        wbm_sel_o = 4'hF;
      end
      S_DONE: mem_opdone = 1'b1;
      S_HOLD: busy = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      we_q        <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        wbm_adr_o <= BASE_ADDR + (mem_addr_i << 2);
        we_q      <= mem_operation[1];
        if (mem_operation[1])
          wbm_dat_o <= mem_wdata_i;
      end
      // Reads only; an aborted read returns a recognisable poison word.
      if (state == S_REQ && !we_q) begin
        if (wbm_ack_i)
          mem_rdata_o <= wbm_dat_i;
        else if (expire)
          mem_rdata_o <= ABORT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_conv_mem_bridge.sv
// Scoreboard bench for conv_mem_bridge with a wait-state Wishbone slave model.
// Timeout cases run only when CONV_BRIDGE_TIMEOUT_EN is defined.
module tb_conv_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_operation = 2'b00;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_opdone;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;
  logic        timeout_err;

  conv_mem_bridge #(
    .BASE_ADDR(32'h3000_0000),
    .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_operation(mem_operation),
    .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_opdone(mem_opdone),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc_n++;

  typedef struct {
    logic [31:0] rdata;
    int          done_cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } wb_t;

  rsp_t rq[$];
  wb_t  wq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: acks after `waits` stalled cycles unless muted.
  int          waits = 0;
  int          wcnt = 0;
  bit          mute = 1'b0;
  bit          late_ack = 1'b0;
  bit          fn_mode = 1'b0;
  logic [31:0] slave_rdata = '0;
  logic        slave_ack = 1'b0;

  always @(negedge clk) begin
    if (wbm_stb_o && !slave_ack && !mute) begin
      if (wcnt >= waits) slave_ack = 1'b1;
      else wcnt++;
    end else begin
      slave_ack = 1'b0;
      if (!wbm_stb_o) wcnt = 0;
    end
  end

  assign wbm_ack_i = slave_ack | late_ack;
  assign wbm_dat_i = fn_mode ? (wbm_adr_o ^ 32'hFFFF_0000) : slave_rdata;

  logic prev_stb = 1'b0;
  always @(negedge clk) begin
    wb_t e;
    if (wbm_stb_o && !prev_stb) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got stb=1 adr=%h expected no cycle",
                 wbm_adr_o);
      end else begin
        e = wq.pop_front();
        chk("wb_adr", wbm_adr_o, e.adr);
        chk("wb_we", {31'b0, wbm_we_o}, {31'b0, e.we});
        chk("wb_sel", {28'b0, wbm_sel_o}, 32'h0000_000F);
        chk("wb_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        if (e.we) chk("wb_dat", wbm_dat_o, e.dat);
      end
    end
    prev_stb = wbm_stb_o;
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    rsp_t r;
    if (mem_opdone) begin
      done_cnt++;
      if (prev_done) begin
        checks++;
        failures++;
        $display("FAIL opdone_width: got 2+ cycles expected 1");
      end
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL opdone_unexpected: got pulse at cycle %0d expected none",
                 cyc_n);
      end else begin
        r = rq.pop_front();
        chk("rdata", mem_rdata_o, r.rdata);
        chk("done_cycle", 32'(cyc_n), 32'(r.done_cyc));
      end
    end
    prev_done = mem_opdone;
  end

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_opdone && n < 60);
    if (!mem_opdone) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no opdone expected one within 60 cycles",
               name);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_adr,
                       input logic [31:0] exp_rd, input int w,
                       input string name);
    wb_t  e;
    rsp_t r;
    @(negedge clk);
    waits = w;
    mem_operation = op;
    mem_addr_i = addr;
    mem_wdata_i = wdata;
    e.adr = exp_adr;
    e.we = op[1];
    e.dat = wdata;
    wq.push_back(e);
    r.rdata = exp_rd;
    r.done_cyc = cyc_n + 2 + w;
    rq.push_back(r);
    @(negedge clk);
    mem_operation = 2'b00;
    mem_addr_i = 32'hFFFF_FFFF;
    wait_done(name);
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] pf_adr [5] = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008,
                              32'h3000_000C, 32'h3000_0010};
  logic [31:0] pf_dat [5] = '{32'hCFFF_0000, 32'hCFFF_0004, 32'hCFFF_0008,
                              32'hCFFF_000C, 32'hCFFF_0010};
  int exp_done = 0;

  initial begin
    wb_t  e;
    rsp_t r;
    int   t0;

    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("rst_we", {31'b0, wbm_we_o}, 32'd0);
    chk("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    chk("rst_opdone", {31'b0, mem_opdone}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_terr", {31'b0, timeout_err}, 32'd0);
    reset = 1'b0;

    slave_rdata = 32'h1234_5678;
    issue(2'b01, 32'd5, 32'd0, 32'h3000_0014, 32'h1234_5678, 0, "rd0");
    exp_done++;

    slave_rdata = 32'h0BAD_0BAD;
    issue(2'b11, 32'd2, 32'hCAFE_0001, 32'h3000_0008, 32'h1234_5678, 3,
          "wr3");
    exp_done++;

    fn_mode = 1'b1;
    waits = 0;
    @(negedge clk);
    mem_operation = 2'b01;
    mem_addr_i = 32'd0;
    t0 = cyc_n;
    for (int i = 0; i < 5; i++) begin
      e.adr = pf_adr[i];
      e.we = 1'b0;
      e.dat = '0;
      wq.push_back(e);
      r.rdata = pf_dat[i];
      r.done_cyc = t0 + 2 + 4 * i;
      rq.push_back(r);
    end
    for (int i = 0; i < 5; i++) begin
      wait_done("pf");
      if (i < 4) mem_addr_i = 32'(i + 1);
      else mem_operation = 2'b00;
    end
    exp_done += 5;
    repeat (2) @(negedge clk);

    mute = 1'b1;
    @(negedge clk);
    mem_operation = 2'b01;
    mem_addr_i = 32'd9;
    e.adr = 32'h3000_0024;
    e.we = 1'b0;
    e.dat = '0;
    wq.push_back(e);
    @(negedge clk);
    mem_operation = 2'b00;
    chk("req_stb", {31'b0, wbm_stb_o}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_rdata", mem_rdata_o, 32'd0);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    chk("late_ack_busy", {31'b0, busy}, 32'd0);
    mute = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_operation = 2'b10;
      mem_addr_i = 32'(i);
      chk("op10_idle", {29'b0, busy, wbm_cyc_o, wbm_stb_o}, 32'd0);
    end
    @(negedge clk);
    mem_operation = 2'b00;
    chk("op10_idle_end", {29'b0, busy, wbm_cyc_o, wbm_stb_o}, 32'd0);
    fn_mode = 1'b0;

`ifdef CONV_BRIDGE_TIMEOUT_EN
    slave_rdata = 32'h0000_0077;
    issue(2'b01, 32'd3, 32'd0, 32'h3000_000C, 32'h0000_0077, 7, "ack_at_exp");
    exp_done++;
    chk("terr_ack_wins", {31'b0, timeout_err}, 32'd0);

    mute = 1'b1;
    issue(2'b01, 32'd7, 32'd0, 32'h3000_001C, 32'hDEAD_BEEF, 7, "tmo");
    exp_done++;
    mute = 1'b0;
    chk("terr_set", {31'b0, timeout_err}, 32'd1);

    slave_rdata = 32'h0000_00A5;
    issue(2'b01, 32'd1, 32'd0, 32'h3000_0004, 32'h0000_00A5, 0, "post_tmo");
    exp_done++;
    chk("terr_sticky", {31'b0, timeout_err}, 32'd1);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("terr_reset", {31'b0, timeout_err}, 32'd0);
`else
    chk("terr_tied", {31'b0, timeout_err}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_mem_bridge.md
# conv_mem_bridge

Memory-side responder for the matrix convolution engine: services its `mem_operation` / `mem_opdone` word-access handshake by issuing single classic Wishbone master cycles into the user-area memory map. Sits directly downstream of the convolution engine. Engine word addresses are translated into byte addresses at a configurable base, and every request is answered with exactly one `mem_opdone` pulse, including aborted ones.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000: byte address of engine word 0.
- `TIMEOUT_CYCLES`, default 16'd255: maximum cycles with strobe asserted before abort. Only used when the timeout feature is compiled in.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset. Sampled only on the rising edge of `clk`.
- `mem_operation`  in  2: request code from the engine. 01 = read, 11 = write, 00 = none, 10 = ignored (treated as none).
- `mem_addr_i`  in  32: engine word address.
- `mem_wdata_i`  in  32: write data.
- `mem_rdata_o`  out  32: read data returned to the engine.
- `mem_opdone`  out  1: one-cycle completion pulse.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each: Wishbone master control.
- `wbm_sel_o`  out  4: byte selects.
- `wbm_adr_o`  out  32: Wishbone byte address.
- `wbm_dat_o`  out  32: Wishbone write data.
- `wbm_dat_i`  in  32: Wishbone read data.
- `wbm_ack_i`  in  1: Wishbone acknowledge.
- `busy`  out  1: high in every state other than IDLE.
- `timeout_err`  out  1: sticky abort flag.

## Operation
- Reset values:
  - All outputs 0, including `mem_rdata_o`, `wbm_sel_o` and `timeout_err`.
  - State is IDLE.
  - Timeout counter is 0.
- IDLE:
  - If `mem_operation` is 01 or 11, latch the request:
    - `wbm_adr_o` ← `BASE_ADDR + (mem_addr_i << 2)`, computed modulo 2^32.
    - `wbm_we_o` ← `mem_operation[1]`.
    - `wbm_dat_o` ← `mem_wdata_i` on writes.
  - Set `wbm_cyc_o` = `wbm_stb_o` = 1 and `wbm_sel_o` = 4'hF, then go to REQ.
- REQ:
  - Hold all Wishbone outputs stable. Engine-side input changes are ignored.
  - When `wbm_ack_i` = 1:
    - On a read, capture `wbm_dat_i` into `mem_rdata_o`. On a write, `mem_rdata_o` is unchanged.
    - Clear cyc, stb, we and sel.
    - Set `mem_opdone` = 1 and go to DONE.
- DONE:
  - `mem_opdone` is high for exactly this one cycle; clear it on leaving.
  - Go to HOLD.
- HOLD:
  - One dead cycle that lets the engine update `addr` / `mem_operation` after seeing `mem_opdone`.
  - Go to IDLE.
- Back-to-back requests: an engine that keeps `mem_operation` = 01 and only advances the address (as in its parameter fetch) is served as a new request on each IDLE visit.
- `wbm_ack_i` outside REQ is ignored.
- Reset mid-transaction:
  - At the reset edge, cyc and stb drop and the state returns to IDLE.
  - No `mem_opdone` is issued.
  - A late ack is ignored.

## Timing
- Request visible in cycle 0 → cyc/stb high in cycle 1.
- Zero-wait ack in cycle 1 → `mem_opdone` high in cycle 2, with `mem_rdata_o` valid in the same cycle and thereafter until the next read completes.
- Each ack wait state adds one cycle.
- Maximum throughput: one transaction per 4 cycles (IDLE, REQ, DONE, HOLD).
- `busy` is 1 from cycle 1 through HOLD inclusive.

## Configuration
- `CONV_BRIDGE_TIMEOUT_EN` defined:
  - A 16-bit counter increments each REQ cycle without ack and clears on entering REQ.
  - When it reaches `TIMEOUT_CYCLES`:
    - Abort: drop cyc, stb and sel.
    - On a read, set `mem_rdata_o` = 32'hDEAD_BEEF.
    - Set `timeout_err` = 1 (sticky, cleared only by reset).
    - Pulse `mem_opdone` via DONE.
  - An ack in the same cycle as expiry wins: normal completion, no error.
- `CONV_BRIDGE_TIMEOUT_EN` undefined:
  - No counter; REQ waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Read, zero-wait slave: `mem_addr_i` = 5, op 01, `wbm_dat_i` = 32'h1234_5678 → `wbm_adr_o` = 32'h3000_0014, `mem_opdone` in cycle 2, `mem_rdata_o` = 32'h1234_5678.
- Write, 3 wait states: addr 2, data 32'hCAFE_0001, op 11 → `wbm_we_o` = 1, `wbm_dat_o` = 32'hCAFE_0001, one `mem_opdone` pulse 3 cycles later than the zero-wait case; `mem_rdata_o` unchanged.
- Parameter-fetch pattern: op held at 01, address stepping 0→4 after each `mem_opdone` → five Wishbone reads at 0x3000_0000–0x3000_0010, each 4 cycles apart, exactly five pulses.
- Reset in REQ: assert `reset` one cycle after stb, slave acks afterwards → cyc/stb 0 after the reset edge, no `mem_opdone`, state IDLE.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 8): slave never acks a read → abort after 8 REQ cycles, `mem_rdata_o` = 32'hDEAD_BEEF, `timeout_err` = 1 and held until reset, one `mem_opdone` pulse.
- Op code 10 presented in IDLE for 10 cycles → no Wishbone activity, `busy` stays 0.
